// File: rtl/urv_dm_wb_bridge_pkg.sv
// Shared types and constants for the uRV data-memory to Wishbone bridge:
// FSM state encodings, the load value returned on a bus error, and the latched request.
package urv_dm_wb_bridge_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [DATA_W-1:0] ERR_LOAD_DATA = 32'h0000_0000;

   typedef struct packed {
      logic [ADDR_W-1:0] adr;
      logic [DATA_W-1:0] dat;
      logic [SEL_W-1:0]  sel;
      logic              we;
   } req_t;

endpackage

// File: rtl/urv_dm_wb_bridge_if.sv
// Wishbone classic bus bundle between the bridge (master) and a slave.
interface urv_dm_wb_bridge_if;
   import urv_dm_wb_bridge_pkg::*;

   logic [ADDR_W-1:0] adr;
   logic [DATA_W-1:0] dat_w;
   logic [DATA_W-1:0] dat_r;
   logic [SEL_W-1:0]  sel;
   logic              we;
   logic              cyc;
   logic              stb;
   logic              ack;
   logic              err;

   modport master (output adr, dat_w, sel, we, cyc, stb,
                   input  dat_r, ack, err);
   modport slave  (input  adr, dat_w, sel, we, cyc, stb,
                   output dat_r, ack, err);
endinterface

// File: rtl/urv_dm_wb_timeout.sv
// Bus-cycle watchdog for the bridge; only instantiated when URV_DM_WB_TIMEOUT_EN is defined.
module urv_dm_wb_timeout #(
   parameter int unsigned g_timeout_cycles = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic start,
   input  logic busy,
   output logic expired_c
);
   localparam int unsigned CNT_W = $clog2(g_timeout_cycles + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i || start)
         cnt <= '0;
      else if (busy)
         cnt <= cnt + CNT_W'(1);
   end

   // Fires during the g_timeout_cycles-th BUS cycle so the bus drops right after it.
   assign expired_c = busy && (cnt == CNT_W'(g_timeout_cycles - 1));

endmodule

// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory port to Wishbone classic master bridge (IDLE -> BUS -> DONE).
// Optional bus watchdog enabled by defining URV_DM_WB_TIMEOUT_EN.
module urv_dm_wb_bridge
   import urv_dm_wb_bridge_pkg::*;
#(
   parameter int unsigned g_timeout_cycles = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [ADDR_W-1:0]   dm_addr_i,
   input  logic [DATA_W-1:0]   dm_data_s_i,
   input  logic [SEL_W-1:0]    dm_data_select_i,
   input  logic                dm_store_i,
   input  logic                dm_load_i,
   output logic                dm_ready_o,
   output logic [DATA_W-1:0]   dm_data_l_o,
   output logic                dm_load_done_o,
   output logic                dm_store_done_o,
   output logic                bus_err_o,
   urv_dm_wb_bridge_if.master  wb
);

   if (g_timeout_cycles == 0) begin : g_param_check
      $error("urv_dm_wb_bridge: g_timeout_cycles must be non-zero");
   end

   state_t state;
   req_t   req;
   logic   bus_active;
   logic   accept_c;
   logic   in_bus_c;
   logic   timeout_c;
   logic   err_c;

   assign accept_c = (state == ST_IDLE) && (dm_load_i || dm_store_i);
   assign in_bus_c = (state == ST_BUS);
   assign err_c    = wb.err || timeout_c;

`ifdef URV_DM_WB_TIMEOUT_EN
   urv_dm_wb_timeout #(
      .g_timeout_cycles (g_timeout_cycles)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start     (accept_c),
      .busy      (in_bus_c),
      .expired_c (timeout_c)
   );
`else
   assign timeout_c = 1'b0;
`endif

   assign wb.adr   = req.adr;
   assign wb.dat_w = req.dat;
   assign wb.sel   = req.sel;
   assign wb.we    = req.we;
   assign wb.cyc   = bus_active;
   assign wb.stb   = bus_active;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state           <= ST_IDLE;
         req             <= '0;
         bus_active      <= 1'b0;
         dm_ready_o      <= 1'b1;
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         dm_data_l_o     <= '0;
         bus_err_o       <= 1'b0;
      end else begin
         dm_load_done_o  <= 1'b0;
         dm_store_done_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               // Load has priority; a simultaneous store is dropped.
               if (accept_c) begin
                  req.adr    <= dm_addr_i;
                  req.dat    <= dm_data_s_i;
                  req.sel    <= dm_data_select_i;
                  req.we     <= !dm_load_i;
                  bus_active <= 1'b1;
                  dm_ready_o <= 1'b0;
                  state      <= ST_BUS;
               end
            end
            ST_BUS: begin
               if (wb.ack || err_c) begin
                  bus_active <= 1'b0;
                  state      <= ST_DONE;
                  if (req.we) begin
                     dm_store_done_o <= 1'b1;
                  end else begin
                     dm_load_done_o <= 1'b1;
                     dm_data_l_o    <= err_c ? ERR_LOAD_DATA : wb.dat_r;
                  end
                  if (err_c)
                     bus_err_o <= 1'b1;
               end
            end
            ST_DONE: begin
               dm_ready_o <= 1'b1;
               state      <= ST_IDLE;
            end
            default: begin
               bus_active <= 1'b0;
               dm_ready_o <= 1'b1;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Directed self-checking bench for urv_dm_wb_bridge (both default and URV_DM_WB_TIMEOUT_EN builds).
module tb_urv_dm_wb_bridge;
   import urv_dm_wb_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_data_s = '0;
   logic [3:0]  dm_sel = '0;
   logic        dm_store = 1'b0;
   logic        dm_load = 1'b0;
   logic        dm_ready;
   logic [31:0] dm_data_l;
   logic        load_done;
   logic        store_done;
   logic        bus_err;

   int vectors = 0;
   int errors  = 0;

   urv_dm_wb_bridge_if bus ();

   urv_dm_wb_bridge #(.g_timeout_cycles(8)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .dm_addr_i        (dm_addr),
      .dm_data_s_i      (dm_data_s),
      .dm_data_select_i (dm_sel),
      .dm_store_i       (dm_store),
      .dm_load_i        (dm_load),
      .dm_ready_o       (dm_ready),
      .dm_data_l_o      (dm_data_l),
      .dm_load_done_o   (load_done),
      .dm_store_done_o  (store_done),
      .bus_err_o        (bus_err),
      .wb               (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int pulses;
      int low_cycles;
      bus.dat_r = '0;
      bus.ack   = 1'b0;
      bus.err   = 1'b0;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_ready",   32'(dm_ready), 32'd1);
      check("rst_cyc",     32'(bus.cyc), 32'd0);
      check("rst_stb",     32'(bus.stb), 32'd0);
      check("rst_we",      32'(bus.we), 32'd0);
      check("rst_adr",     bus.adr, 32'h0);
      check("rst_sel",     32'(bus.sel), 32'd0);
      check("rst_data_l",  dm_data_l, 32'h0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_done",    32'({load_done, store_done}), 32'd0);

      // Load 0x1000, one wait state, ack with 0xCAFEBABE
      dm_addr = 32'h0000_1000; dm_load = 1'b1;
      tick();
      dm_load = 1'b0;
      check("ldA_stb1",  32'(bus.stb), 32'd1);
      check("ldA_cyc1",  32'(bus.cyc), 32'd1);
      check("ldA_we",    32'(bus.we), 32'd0);
      check("ldA_adr",   bus.adr, 32'h0000_1000);
      check("ldA_ready", 32'(dm_ready), 32'd0);
      tick();
      check("ldA_stb2",  32'(bus.stb), 32'd1);
      bus.ack = 1'b1; bus.dat_r = 32'hCAFE_BABE;
      tick();
      bus.ack = 1'b0; bus.dat_r = 32'h0;
      check("ldA_cyc_off", 32'(bus.cyc), 32'd0);
      check("ldA_ldone",   32'(load_done), 32'd1);
      check("ldA_sdone",   32'(store_done), 32'd0);
      check("ldA_data",    dm_data_l, 32'hCAFE_BABE);
      check("ldA_ready_d", 32'(dm_ready), 32'd0);
      tick();
      check("ldA_ldone_off", 32'(load_done), 32'd0);
      check("ldA_ready_i",   32'(dm_ready), 32'd1);

      // Store 0x2004 / 0x12345678 / sel 0011, ack after 5 waits; stray load mid-BUS is ignored
      dm_addr = 32'h0000_2004; dm_data_s = 32'h1234_5678; dm_sel = 4'b0011; dm_store = 1'b1;
      tick();
      dm_store = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         check("stB_stb", 32'(bus.stb), 32'd1);
         check("stB_we",  32'(bus.we), 32'd1);
         check("stB_sel", 32'(bus.sel), 32'h3);
         check("stB_adr", bus.adr, 32'h0000_2004);
         check("stB_dat", bus.dat_w, 32'h1234_5678);
         pulses += int'(load_done) + int'(store_done);
         dm_load = (i == 2);
         dm_addr = (i == 2) ? 32'h0000_9999 : 32'h0000_2004;
         bus.ack = (i == 5);
         tick();
      end
      dm_load = 1'b0; bus.ack = 1'b0;
      check("stB_early_pulses", 32'(pulses), 32'd0);
      check("stB_sdone", 32'(store_done), 32'd1);
      check("stB_ldone", 32'(load_done), 32'd0);
      check("stB_cyc_off", 32'(bus.cyc), 32'd0);
      tick();
      check("stB_sdone_off", 32'(store_done), 32'd0);
      check("stB_ready", 32'(dm_ready), 32'd1);
      check("stB_data_l_held", dm_data_l, 32'hCAFE_BABE);
      tick();
      check("stB_no_ghost", 32'(bus.cyc), 32'd0);

      // Ack/err outside BUS have no effect
      bus.ack = 1'b1; bus.err = 1'b1;
      tick();
      bus.ack = 1'b0; bus.err = 1'b0;
      tick();
      check("idle_resp_err",  32'(bus_err), 32'd0);
      check("idle_resp_done", 32'({load_done, store_done}), 32'd0);

      // Load and store together: only the load goes out, zero-wait ack, 3-cycle turnaround
      dm_addr = 32'h0000_3000; dm_data_s = 32'hDEAD_BEEF; dm_sel = 4'hF;
      dm_load = 1'b1; dm_store = 1'b1;
      tick();
      dm_load = 1'b0; dm_store = 1'b0;
      check("both_we",  32'(bus.we), 32'd0);
      check("both_stb", 32'(bus.stb), 32'd1);
      bus.ack = 1'b1; bus.dat_r = 32'h1122_3344;
      tick();
      bus.ack = 1'b0;
      check("both_ldone", 32'(load_done), 32'd1);
      check("both_sdone", 32'(store_done), 32'd0);
      check("both_data",  dm_data_l, 32'h1122_3344);
      tick();
      check("both_ready", 32'(dm_ready), 32'd1);
      tick();
      check("both_no_store", 32'(bus.cyc), 32'd0);

      // Load terminated by err: data 0, sticky bus_err
      dm_addr = 32'h0000_4000; dm_load = 1'b1;
      tick();
      dm_load = 1'b0;
      bus.err = 1'b1; bus.dat_r = 32'hFFFF_FFFF;
      tick();
      bus.err = 1'b0;
      check("err_ldone", 32'(load_done), 32'd1);
      check("err_data",  dm_data_l, 32'h0);
      check("err_flag",  32'(bus_err), 32'd1);
      tick(); tick(); tick();
      check("err_sticky", 32'(bus_err), 32'd1);
      check("err_ready",  32'(dm_ready), 32'd1);

      // Silent slave
      dm_addr = 32'h0000_5000; dm_load = 1'b1;
      tick();
      dm_load = 1'b0;
`ifdef URV_DM_WB_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         check("to_cyc_hold", 32'(bus.cyc), 32'd1);
         tick();
      end
      check("to_cyc_off", 32'(bus.cyc), 32'd0);
      check("to_ldone",   32'(load_done), 32'd1);
      check("to_data",    dm_data_l, 32'h0);
      check("to_flag",    32'(bus_err), 32'd1);
      tick();
      check("to_ready",   32'(dm_ready), 32'd1);
`else
      low_cycles = 0;
      for (int i = 0; i < 1000; i++) begin
         if (!bus.cyc || load_done) low_cycles++;
         tick();
      end
      check("silent_cyc_held", 32'(low_cycles), 32'd0);
      check("silent_cyc_end",  32'(bus.cyc), 32'd1);
`endif

      // Reset in the middle of a BUS cycle: bus drops, no completion pulse
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dm_addr = 32'h0000_6000; dm_data_s = 32'hA5A5_A5A5; dm_store = 1'b1;
      tick();
      dm_store = 1'b0;
      check("mrst_in_bus", 32'(bus.cyc), 32'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_cyc",   32'(bus.cyc), 32'd0);
      check("mrst_stb",   32'(bus.stb), 32'd0);
      check("mrst_ready", 32'(dm_ready), 32'd1);
      check("mrst_done",  32'({load_done, store_done}), 32'd0);
      check("mrst_err",   32'(bus_err), 32'd0);
      tick();
      check("mrst_done2", 32'({load_done, store_done}), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
